pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 104 ++++++++++
 tb/tb_pipelined_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract whose carry chain is cut into SLICES
// registered segments, with one valid/ready stall enable shared by every stage.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int SLICES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);
    localparam int SW = WIDTH / SLICES;

    if (WIDTH < 1 || SLICES < 1 || (WIDTH % SLICES) != 0) begin : g_param_check
        $error("pipelined_adder: SLICES must be >= 1 and divide WIDTH exactly");
    end

    logic                adv_s;
    logic [SLICES-1:0]   v_src_s;
    logic [SLICES-1:0]   c_src_s;
    logic [SLICES-1:0]   c_next_s;
    logic [WIDTH-1:0]    a_src_s    [SLICES];
    logic [WIDTH-1:0]    b_src_s    [SLICES];
    logic [WIDTH-1:0]    sum_src_s  [SLICES];
    logic [WIDTH-1:0]    sum_next_s [SLICES];
    logic [SW:0]         slice_s    [SLICES];
    logic                ovf_s;

    logic [SLICES-1:0]   valid_r;
    logic [SLICES-1:0]   carry_r;
    logic [WIDTH-1:0]    a_r   [SLICES];
    logic [WIDTH-1:0]    b_r   [SLICES];
    logic [WIDTH-1:0]    sum_r [SLICES];
    logic                ovf_r;

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < SLICES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // subtraction folds into the adder as A + ~B + ~borrow
            assign v_src_s[k]   = in_valid;
            assign c_src_s[k]   = in_c ^ in_sub;
            assign a_src_s[k]   = in_a;
            assign b_src_s[k]   = in_b ^ {WIDTH{in_sub}};
            assign sum_src_s[k] = {WIDTH{1'b0}};
        end else begin : g_body
            assign v_src_s[k]   = valid_r[k-1];
            assign c_src_s[k]   = carry_r[k-1];
            assign a_src_s[k]   = a_r[k-1];
            assign b_src_s[k]   = b_r[k-1];
            assign sum_src_s[k] = sum_r[k-1];
        end

        assign slice_s[k] = {1'b0, a_src_s[k][k*SW +: SW]}
                          + {1'b0, b_src_s[k][k*SW +: SW]}
                          + {{SW{1'b0}}, c_src_s[k]};
        assign c_next_s[k] = slice_s[k][SW];
        // slices at and above k are still zero in the deskew word, so OR merges
        assign sum_next_s[k] = sum_src_s[k] | (WIDTH'(slice_s[k][SW-1:0]) << (k*SW));
    end

    // carry into the MSB is recovered as a ^ b ^ sum at that bit
    assign ovf_s = a_src_s[SLICES-1][WIDTH-1] ^ b_src_s[SLICES-1][WIDTH-1]
                 ^ slice_s[SLICES-1][SW-1] ^ slice_s[SLICES-1][SW];

    // every stage advances on one enable so a stall freezes the pipe as a unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {SLICES{1'b0}};
            carry_r <= {SLICES{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < SLICES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else if (adv_s) begin
            valid_r <= v_src_s;
            carry_r <= c_next_s;
            ovf_r   <= ovf_s;
            for (int k = 0; k < SLICES; k++) begin
                a_r[k]   <= a_src_s[k];
                b_r[k]   <= b_src_s[k];
                sum_r[k] <= sum_next_s[k];
            end
        end
    end

    assign out_valid = valid_r[SLICES-1];
    assign out_carry = carry_r[SLICES-1];
    assign out_sum   = sum_r[SLICES-1];
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three configurations driven from shared stimulus,
// each checked against an arithmetic scoreboard plus directed literal results.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_c = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;

    logic [2:0]  o_valid, o_carry, o_ovf, rdy;
    logic [15:0] s16;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic [31:0] o_sum [3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;
    int wtab [3] = '{16, 8, 32};
    int ltab [3] = '{4, 1, 8};

    logic [33:0] sb [3][$];
    int          ts [3][$];
    logic [33:0] prev [3];
    logic [2:0]  held = 3'b000;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .SLICES(4)) u_a16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_c(in_c), .in_sub(in_sub),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_sum(s16),
        .out_carry(o_carry[0]), .out_ovf(o_ovf[0]));

    pipelined_adder #(.WIDTH(8), .SLICES(1)) u_a8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_c(in_c), .in_sub(in_sub),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_sum(s8),
        .out_carry(o_carry[1]), .out_ovf(o_ovf[1]));

    pipelined_adder #(.WIDTH(32), .SLICES(8)) u_a32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_sub(in_sub),
        .out_valid(o_valid[2]), .out_ready(out_ready), .out_sum(s32),
        .out_carry(o_carry[2]), .out_ovf(o_ovf[2]));

    assign o_sum[0] = {16'd0, s16};
    assign o_sum[1] = {24'd0, s8};
    assign o_sum[2] = s32;

    // Reference: plain modular arithmetic, overflow from operand/result signs.
    function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                          logic c, logic sub);
        logic [63:0] mask, ua, ub, t, tm;
        logic cin, co, ov;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        cin  = sub ? ~c : c;
        t    = ua + ub + {63'd0, cin};
        tm   = t & mask;
        co   = t[w];
        ov   = (ua[w-1] == ub[w-1]) && (tm[w-1] != ua[w-1]);
        return {ov, co, tm[31:0]};
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, d, act, exp);
        end
    endtask

    function automatic logic [63:0] outw(int d);
        return {30'd0, o_ovf[d], o_carry[d], o_sum[d]};
    endfunction

    // model side: record every operation each configuration accepts
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (in_valid && rdy[d]) begin
                    sb[d].push_back(model(wtab[d], in_a, in_b, in_c, in_sub));
                    ts[d].push_back(cyc);
                end
            end
        end
    end

    // compare process: handshake rule, hold stability and in-order results
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 3'b000;
        end else begin
            for (int d = 0; d < 3; d++) begin
                chk("in_ready", d, 64'(rdy[d]), 64'(!o_valid[d] || out_ready));
                if (held[d]) begin
                    chk("hold_valid", d, 64'(o_valid[d]), 64'd1);
                    chk("hold_data", d, outw(d), 64'(prev[d]));
                end
                if (o_valid[d] && out_ready) begin
                    if (sb[d].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_valid dut%0d: got out_valid=1, expected no result", d);
                    end else begin
                        logic [33:0] e;
                        int st;
                        e  = sb[d].pop_front();
                        st = ts[d].pop_front();
                        chk("result", d, outw(d), 64'(e));
                        if (lat_chk) chk("latency", d, 64'(cyc - st), 64'(ltab[d]));
                    end
                end
                held[d] = o_valid[d] && !out_ready;
                prev[d] = outw(d)[33:0];
            end
        end
    end

    task automatic dir(int d, logic [31:0] a, logic [31:0] b, logic c, logic sub,
                       logic [33:0] exp);
        int k;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_sub = sub; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!o_valid[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("dir_valid", d, 64'(o_valid[d]), 64'd1);
        chk("dir_value", d, outw(d), 64'(exp));
        repeat (10) @(posedge clk);
    endtask

    task automatic run_ops(int n, bit rnd);
        int  sent = 0;
        int  k = 0;
        bit  acc;
        while (sent < n && k < 4000) begin
            #1;
            in_valid  = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
            in_a      = $urandom;
            in_b      = $urandom;
            in_c      = 1'($urandom_range(0, 1));
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(k >= 5 && k < 8);
            @(negedge clk);
            acc = in_valid && rdy[0];
            @(posedge clk);
            if (acc) sent++;
            k++;
        end
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("ops_accepted", 0, 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int k = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 0, 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
        @(posedge clk);
    endtask

    task automatic directed_set();
        dir(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        dir(0, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00008000});
        dir(0, 32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000FFFE});
        dir(1, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        dir(1, 32'h0000007F, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00000080});
        dir(1, 32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'h000000FE});
        dir(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        dir(2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000});
        dir(2, 32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", d, 64'(o_valid[d]), 64'd0);
            chk("reset_data", d, outw(d), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("ready_after_reset", d, 64'(rdy[d]), 64'd1);

        lat_chk = 1'b1;
        directed_set();
        // carries rippling across each 4-bit slice boundary of the 16-bit pipe
        dir(0, 32'h0000000F, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000010});
        dir(0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000100});
        dir(0, 32'h00000FFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00001000});
        dir(0, 32'h00000000, 32'h0000FFFF, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000000});
        lat_chk = 1'b0;

        @(posedge clk);
        run_ops(8, 1'b0);
        drain();

        // reset with operations in flight
        for (int i = 0; i < 3; i++) begin
            #1;
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'b0; in_c = 1'b0;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("midrst_valid", d, 64'(o_valid[d]), 64'd0);
            chk("midrst_data", d, outw(d), 64'd0);
            sb[d].delete();
            ts[d].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        lat_chk = 1'b1;
        dir(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000});
        lat_chk = 1'b0;

        @(posedge clk);
        run_ops(1000, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
